bin2bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly downstream of the rounding stage. It consumes the 13-bit rounded magnitude (temperature x10) and produces four packed BCD digits for the seven-segment display driver.
- A sign bit is carried alongside the value so the display stage receives the sign and digits together.
- Start/busy/done handshake; one conversion per W+1 clocks.

---
 rtl/bin2bcd_pkg.sv | 30 +++
 rtl/bcd_add3.sv | 18 +
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 tb/tb_bin2bcd_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Default geometry: 13-bit magnitude (temperature x10), four display digits
  localparam int W_DEFAULT      = 13;
  localparam int DIGITS_DEFAULT = 4;
  localparam int BCD_W          = 4 * DIGITS_DEFAULT;
  localparam int CNT_W          = $clog2(W_DEFAULT);

  // Converter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One packed BCD digit
  typedef logic [3:0] bcd_digit_t;

  // 10**n as a constant expression, used for the digit-capacity check
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to any digit of 5 or more so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Correct the digit ahead of the shift
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter. Takes the rounded magnitude
// plus its sign and, W clocks later, presents packed BCD digits and the sign
// together for the seven-segment driver.
//
// Handshake: start is sampled on a rising edge while busy=0 (IDLE or DONE);
// bin and sign_in are captured on that edge. busy is high for exactly W
// cycles while shifting and start is ignored then. done is a single-cycle
// pulse marking bcd/sign_out as newly valid; those outputs hold until the
// next done pulse.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        bin,
  input  logic                sign_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                sign_out
);

  localparam int SCR_W    = 4 * DIGITS;
  localparam int CNT_BITS = $clog2(W);

  // The digit field must be able to hold the largest W-bit value
  if (pow10(DIGITS) <= ((longint'(1) << W) - 1)) begin : g_digits_too_few
    $error("bin2bcd_seq: DIGITS too small for W");
  end
  if (W < 2) begin : g_w_too_small
    $error("bin2bcd_seq: W must be at least 2");
  end

  state_t               state;
  logic [W-1:0]         bin_q;
  logic [SCR_W-1:0]     scr_q;
  logic [SCR_W-1:0]     scr_cor;
  logic [CNT_BITS-1:0]  cnt_q;
  logic                 sign_q;
  logic [SCR_W+W-1:0]   shift_nxt;

  // One corrector per scratch digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr_q[4*g +: 4]),
      .dout (scr_cor[4*g +: 4])
    );
  end

  // Corrected scratch and binary register move left together as one word
  assign shift_nxt = {scr_cor, bin_q} << 1;

  // Sequencer: load on start, W correct-then-shift iterations, one done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      sign_out <= 1'b0;
      bin_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bin_q  <= bin;
            scr_q  <= '0;
            sign_q <= sign_in;
            cnt_q  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          scr_q <= shift_nxt[SCR_W+W-1:W];
          bin_q <= shift_nxt[W-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_BITS'(W - 1)) begin
            bcd      <= shift_nxt[SCR_W+W-1:W];
            sign_out <= sign_q;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, start-while-busy,
// back-to-back, mid-conversion reset and a randomized sweep.
module tb_bin2bcd_seq;

  localparam int W      = 13;
  localparam int DIGITS = 4;
  localparam int BW     = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  bin = '0;
  logic          sign_in = 1'b0;
  logic          busy;
  logic          done;
  logic [BW-1:0] bcd;
  logic          sign_out;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .sign_in  (sign_in),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .sign_out (sign_out)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int started  = 0;
  logic [BW:0] exp_q[$];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Reference: decimal digits by plain division
  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One conversion; poke re-asserts start (with bin=77) while busy
  task automatic run_conv(input logic [W-1:0] b, input logic s, input bit poke);
    int lat;
    int busy_n;
    bit got;
    logic [BW:0] e;
    @(negedge clk);
    start = 1'b1; bin = b; sign_in = s;
    exp_q.push_back({s, ref_bcd(int'(b))});
    started++;
    lat = 0; busy_n = 0; got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        lat = i - 1;
      end else if (busy === 1'b1) begin
        busy_n++;
      end
      start   = poke && (i == 3 || i == 7);
      bin     = poke ? W'(77) : W'($urandom);
      sign_in = ~s;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      check("latency", 32'(lat), 32'(W));
      check("busy_cycles", 32'(busy_n), 32'(W));
      check("bcd", 32'(bcd), 32'(e[BW-1:0]));
      check("sign_out", 32'(sign_out), 32'(e[BW]));
      check("busy_in_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int dc0;
    int t1;
    int t2;
    bit stable;
    logic [BW-1:0] held;
    logic [BW:0] e;
    int corners[10] = '{0, 1, 9, 10, 99, 100, 999, 1000, 8190, 8191};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_sign", 32'(sign_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed values
    run_conv(W'(0), 1'b0, 0);
    run_conv(W'(1234), 1'b1, 0);
    check("dir_1234", 32'(bcd), 32'h1234);
    run_conv(W'(8191), 1'b0, 0);
    check("dir_8191", 32'(bcd), 32'h8191);
    run_conv(W'(9), 1'b0, 0);
    run_conv(W'(10), 1'b1, 0);
    check("dir_10", 32'(bcd), 32'h0010);

    // start pulses while busy must be ignored
    dc0 = done_cnt;
    run_conv(W'(500), 1'b0, 1);
    check("poke_bcd", 32'(bcd), 32'h0500);
    check("poke_one_done", 32'(done_cnt - dc0), 32'd1);
    repeat (20) @(negedge clk);
    check("poke_no_second", 32'(done_cnt - dc0), 32'd1);
    check("poke_idle", 32'(busy), 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; bin = W'(250); sign_in = 1'b0;
    exp_q.push_back({1'b0, ref_bcd(250)});
    exp_q.push_back({1'b0, ref_bcd(251)});
    started += 2;
    t1 = -1; t2 = -1; stable = 1; held = '0;
    for (int i = 1; i <= 60 && t2 < 0; i++) begin
      @(negedge clk);
      if (i == 1) bin = W'(251);
      if (i == 15) start = 1'b0;
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        check("bb_bcd", 32'(bcd), 32'(e[BW-1:0]));
        if (t1 < 0) begin
          t1 = i;
          held = bcd;
        end else begin
          t2 = i;
        end
      end else if (t1 >= 0 && bcd !== held) begin
        stable = 0;
      end
    end
    start = 1'b0;
    check("bb_first_at", 32'(t1), 32'd14);
    check("bb_period", 32'(t2 - t1), 32'd14);
    check("bb_stable", 32'(stable), 32'd1);
    check("bb_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Reset during shift cycle 6
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; bin = W'(4321); sign_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bcd", 32'(bcd), 32'd0);
    check("arst_sign", 32'(sign_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_done", 32'(done_cnt - dc0), 32'd0);
    run_conv(W'(42), 1'b0, 0);
    check("arst_after", 32'(bcd), 32'h0042);

    // Boundary values and randomized sweep
    foreach (corners[k]) run_conv(W'(corners[k]), 1'(k), 0);
    for (int n = 0; n < 1500; n++) begin
      run_conv(W'($urandom_range(8191, 0)), 1'($urandom_range(1, 0)), 0);
    end

    check("done_total", 32'(done_cnt), 32'(started));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
